// File: rtl/regwrite_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regwrite_buffer_pkg
//  Brief    : Shared definitions for the register write-back buffer:
//             register address width, the hard-wired zero register and the
//             layout of a buffered write entry.
//  Revision : 1.0 - initial release
// ============================================================================
package regwrite_buffer_pkg;

  // The register file has 16 entries, so addresses are 4 bits wide.
  localparam int REG_AW = 4;

  typedef logic [REG_AW-1:0] reg_addr_t;

  // r0 always reads as zero; writes to it are dropped.
  localparam reg_addr_t REG_ZERO = 4'd0;

  // Entry record layout is {addr[REG_AW-1:0], data[width-1:0]}: the address
  // occupies the top REG_AW bits and the data the low bits.
  function automatic int entry_w(input int width);
    return REG_AW + width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regwrite_match.sv
`default_nettype none
// ============================================================================
//  Module   : regwrite_match
//  Brief    : Combinational youngest-match search over the occupied buffer
//             entries. Returns whether any pending write targets ra and, if
//             so, the data of the one nearest the write pointer.
//  Revision : 1.0 - initial release
// ============================================================================
module regwrite_match
  import regwrite_buffer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic [DEPTH-1:0][entry_w(WIDTH)-1:0] entries,
  input  logic [DEPTH-1:0]                     valid,
  input  logic [PTRW-1:0]                      rp,
  input  reg_addr_t                            ra,
  output logic                                 hit,
  output logic [WIDTH-1:0]                     data
);

  localparam int EW = entry_w(WIDTH);

  // Walk from the oldest entry (rp) towards the youngest; a later match
  // overrides an earlier one, so the youngest matching entry wins.
  always_comb begin
    logic [PTRW-1:0] idx;
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rp + PTRW'(k);
      if (ra != REG_ZERO && valid[idx] && entries[idx][EW-1:WIDTH] == ra) begin
        hit  = 1'b1;
        data = entries[idx][WIDTH-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regwrite_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : regwrite_buffer
//  Brief    : In-order write-back buffer in front of the register file's
//             single write port, with a two-port bypass lookup so decode
//             sees the youngest value still pending.
//  Revision : 1.0 - initial release
// ============================================================================
module regwrite_buffer
  import regwrite_buffer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_addr,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              drain_en,
  output logic              we3,
  output logic [REG_AW-1:0] wa3,
  output logic [WIDTH-1:0]  wd3,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic              hit1,
  output logic              hit2,
  output logic [WIDTH-1:0]  byp1,
  output logic [WIDTH-1:0]  byp2,
  output logic [PTRW:0]     count,
  output logic              full,
  output logic              empty
);

  localparam int EW = entry_w(WIDTH);

  logic [DEPTH-1:0][EW-1:0] entries_q, entries_d;
  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [PTRW-1:0]          wp_q, wp_d;
  logic [PTRW-1:0]          rp_q, rp_d;
  logic [PTRW:0]            count_q, count_d;

  logic accept;
  logic push;
  logic pop;

  // Flags come straight from registered state, so in_ready never depends on
  // a same-cycle drain and reset forces them immediately.
  assign full     = (count_q == (PTRW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign in_ready = !full;

  // A request to r0 is consumed but never stored.
  assign accept = in_valid && in_ready;
  assign push   = accept && (in_addr != REG_ZERO);
  assign pop    = !empty && drain_en;

  assign we3 = pop;
  assign wa3 = entries_q[rp_q][EW-1:WIDTH];
  assign wd3 = entries_q[rp_q][WIDTH-1:0];

  // Next-state for pointers, occupancy and storage from this cycle's push/pop.
  always_comb begin
    entries_d = entries_q;
    valid_d   = valid_q;
    wp_d      = wp_q;
    rp_d      = rp_q;
    count_d   = count_q;
    if (pop) begin
      valid_d[rp_q] = 1'b0;
      rp_d          = rp_q + PTRW'(1);
    end
    if (push) begin
      entries_d[wp_q] = {in_addr, in_data};
      valid_d[wp_q]   = 1'b1;
      wp_d            = wp_q + PTRW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + (PTRW+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (PTRW+1)'(1);
    end
  end

  // State registers; reset discards every pending write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entries_q <= '0;
      valid_q   <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      valid_q   <= valid_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      count_q   <= count_d;
    end
  end

  // One youngest-match search per decode read port. The head entry being
  // drained still counts, since the file only updates at the edge.
  regwrite_match #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTRW  (PTRW)
  ) u_match1 (
    .entries (entries_q),
    .valid   (valid_q),
    .rp      (rp_q),
    .ra      (ra1),
    .hit     (hit1),
    .data    (byp1)
  );

  regwrite_match #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTRW  (PTRW)
  ) u_match2 (
    .entries (entries_q),
    .valid   (valid_q),
    .rp      (rp_q),
    .ra      (ra2),
    .hit     (hit2),
    .data    (byp2)
  );

endmodule
`default_nettype wire

// File: tb/tb_regwrite_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regwrite_buffer
//  Brief    : Directed self-checking bench for regwrite_buffer with a small
//             register-file model capturing the write port.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regwrite_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_addr;
  logic [7:0] in_data;
  logic       drain_en;
  logic       we3;
  logic [3:0] wa3;
  logic [7:0] wd3;
  logic [3:0] ra1, ra2;
  logic       hit1, hit2;
  logic [7:0] byp1, byp2;
  logic [2:0] count;
  logic       full, empty;

  int tests = 0;
  int fails = 0;
  int mark;

  logic [7:0]  rf [16];
  logic [11:0] wlog [$];

  always #5 clk = ~clk;

  regwrite_buffer #(.WIDTH(8), .DEPTH(4), .PTRW(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .drain_en (drain_en),
    .we3      (we3),
    .wa3      (wa3),
    .wd3      (wd3),
    .ra1      (ra1),
    .ra2      (ra2),
    .hit1     (hit1),
    .hit2     (hit2),
    .byp1     (byp1),
    .byp2     (byp2),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // Register file model: captures the write port at the rising edge.
  always @(posedge clk) begin
    if (we3) begin
      rf[wa3] <= wd3;
      wlog.push_back({wa3, wd3});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input int idx, input logic [3:0] a, input logic [7:0] d);
    if (mark + idx < wlog.size())
      check($sformatf("wlog[%0d]", idx), {20'd0, wlog[mark + idx]}, {20'd0, a, d});
    else
      check($sformatf("wlog_len_%0d", idx), wlog.size(), mark + idx + 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_addr = 4'd0; in_data = 8'd0;
    drain_en = 1'b0; ra1 = 4'd3; ra2 = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_we3", we3, 0);
    check("rst_hit1", hit1, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b0;

    // T1: single write, latency check
    mark = wlog.size();
    drain_en = 1'b1; in_valid = 1'b1; in_addr = 4'd3; in_data = 8'h5A;
    #1;
    check("t1_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    #1;
    check("t1_we3", we3, 1);
    check("t1_wa3", wa3, 3);
    check("t1_wd3", wd3, 8'h5A);
    check("t1_count", count, 1);
    check("t1_hit1", hit1, 1);
    check("t1_byp1", byp1, 8'h5A);
    step();
    check("t1_empty", empty, 1);
    check("t1_rf3", rf[3], 8'h5A);
    check_log(0, 4'd3, 8'h5A);

    // T2: fill while frozen, back-pressure, ordered drain
    mark = wlog.size();
    drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_addr = 4'(i); in_data = 8'(i * 8'h11);
      step();
    end
    in_addr = 4'd6; in_data = 8'h66;
    #1;
    check("t2_full", full, 1);
    check("t2_in_ready", in_ready, 0);
    check("t2_count", count, 4);
    check("t2_we3_frozen", we3, 0);
    step();
    check("t2_held_count", count, 4);
    drain_en = 1'b1;
    #1;
    check("t2_we3", we3, 1);
    check("t2_wa3_first", wa3, 1);
    check("t2_wd3_first", wd3, 8'h11);
    check("t2_in_ready_full", in_ready, 0);
    step();
    check("t2_count_after_pop", count, 3);
    check("t2_in_ready_drop", in_ready, 1);
    check("t2_wa3_second", wa3, 2);
    step();
    in_valid = 1'b0;
    check("t2_count_pushpop", count, 3);
    check("t2_wa3_third", wa3, 3);
    repeat (3) step();
    check("t2_empty", empty, 1);
    check_log(0, 4'd1, 8'h11);
    check_log(1, 4'd2, 8'h22);
    check_log(2, 4'd3, 8'h33);
    check_log(3, 4'd4, 8'h44);
    check_log(4, 4'd6, 8'h66);

    // T3: two writes to the same register, youngest bypass
    mark = wlog.size();
    drain_en = 1'b0;
    in_valid = 1'b1; in_addr = 4'd5; in_data = 8'h10;
    step();
    in_data = 8'h20;
    step();
    in_valid = 1'b0; ra1 = 4'd5;
    #1;
    check("t3_count", count, 2);
    check("t3_hit1", hit1, 1);
    check("t3_byp1", byp1, 8'h20);
    drain_en = 1'b1;
    step();
    check("t3_hit1_mid", hit1, 1);
    check("t3_byp1_mid", byp1, 8'h20);
    step();
    check("t3_empty", empty, 1);
    check("t3_hit1_after", hit1, 0);
    check("t3_byp1_after", byp1, 0);
    check("t3_rf5", rf[5], 8'h20);
    check_log(0, 4'd5, 8'h10);
    check_log(1, 4'd5, 8'h20);

    // T4: writes to r0 are consumed and dropped
    mark = wlog.size();
    in_valid = 1'b1; in_addr = 4'd0; in_data = 8'hFF; ra2 = 4'd0;
    #1;
    check("t4_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("t4_count", count, 0);
    check("t4_we3", we3, 0);
    check("t4_hit2", hit2, 0);
    check("t4_byp2", byp2, 0);
    step();
    check("t4_wlog_len", wlog.size(), mark);

    // T5: simultaneous push/pop at count 2, then pointer wrap
    mark = wlog.size();
    drain_en = 1'b0;
    in_valid = 1'b1; in_addr = 4'd7; in_data = 8'h71;
    step();
    in_addr = 4'd8; in_data = 8'h82;
    step();
    in_addr = 4'd9; in_data = 8'h93; drain_en = 1'b1;
    #1;
    check("t5_count_before", count, 2);
    step();
    in_valid = 1'b0;
    check("t5_count_same", count, 2);
    check("t5_wa3_head", wa3, 8);
    repeat (2) step();
    check("t5_empty", empty, 1);
    ra1 = 4'd2;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_addr = 4'(10 + (i % 6)); in_data = 8'(8'hA0 + i);
      step();
      ra2 = 4'(10 + (i % 6));
      #1;
      check($sformatf("t5_nohit_%0d", i), hit1, 0);
      check($sformatf("t5_hit2_%0d", i), {hit2, byp2}, {1'b1, 8'(8'hA0 + i)});
    end
    in_valid = 1'b0;
    step();
    check("t5_empty_end", empty, 1);
    check_log(0, 4'd7, 8'h71);
    check_log(1, 4'd8, 8'h82);
    check_log(2, 4'd9, 8'h93);
    for (int i = 0; i < 12; i++)
      check_log(3 + i, 4'(10 + (i % 6)), 8'(8'hA0 + i));

    // T6: asynchronous reset discards pending writes
    drain_en = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_addr = 4'(i); in_data = 8'(8'hD0 + i);
      step();
    end
    in_valid = 1'b0;
    check("t6_count_pending", count, 3);
    mark = wlog.size();
    drain_en = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("t6_count", count, 0);
    check("t6_empty", empty, 1);
    check("t6_we3", we3, 0);
    step();
    reset = 1'b0;
    repeat (4) step();
    check("t6_wlog_len", wlog.size(), mark);
    check("t6_rf1", rf[1], 8'h11);
    check("t6_rf3", rf[3], 8'h33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
